// File: rtl/riva_pkg.sv
// riva_pkg: request/transaction types, mode decode and size helpers for the segment fragmenter.
package riva_pkg;

    localparam int IdWidth      = 4;
    localparam int LenWidth     = 16;
    localparam int MaxAddrWidth = 64;
    localparam int NbytesWidth  = 16;

    typedef enum logic {MOP_UNIT, MOP_STRIDED} mop_e;

    typedef enum logic [1:0] {IDLE, SEG_INIT, STALL, FRAG} seg_state_e;

    typedef struct packed {
        logic [IdWidth-1:0]      req_id;
        logic                    is_load;
        mop_e                    mop;
        logic [1:0]              sew;
        logic [LenWidth-1:0]     len;
        logic [LenWidth-1:0]     vstart;
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] stride;
    } seg_req_t;

    typedef struct packed {
        logic [IdWidth-1:0]      req_id;
        logic [MaxAddrWidth-1:0] addr;
        logic [NbytesWidth-1:0]  nbytes;
        logic                    is_load;
        logic                    last_seg;
        logic                    last_req;
    } frag_txn_t;

    function automatic logic is_strided(input mop_e mop);
        return mop == MOP_STRIDED;
    endfunction

    function automatic logic [3:0] elem_bytes(input logic [1:0] sew);
        return 4'd1 << sew;
    endfunction

    function automatic logic [MaxAddrWidth-1:0] size_min(input logic [MaxAddrWidth-1:0] a,
                                                         input logic [MaxAddrWidth-1:0] b,
                                                         input logic [MaxAddrWidth-1:0] c);
        logic [MaxAddrWidth-1:0] ab;
        ab = a < b ? a : b;
        return ab < c ? ab : c;
    endfunction

endpackage

// File: rtl/vlsu_req_fifo.sv
// vlsu_req_fifo: power-of-two request FIFO with flush; push and pop may coincide when full.
module vlsu_req_fifo #(
    parameter int  Depth = 2,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    T                mem [Depth];
    logic [PtrW-1:0] wptr, rptr;
    logic [CntW-1:0] cnt;

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return p == PtrW'(Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    assign full  = cnt == CntW'(Depth);
    assign empty = cnt == '0;
    assign rdata = mem[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= inc(wptr);
            if (pop) rptr <= inc(rptr);
            cnt <= cnt + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/vlsu_seg_fragmenter.sv
// vlsu_seg_fragmenter: splits unit-stride/strided vector memory requests into
// page- and burst-bounded transactions.
module vlsu_seg_fragmenter #(
    parameter int  ReqQueueDepth = 2,
    parameter int  AddrWidth     = 64,
    parameter int  PageBytes     = 4096,
    parameter int  MaxBurstBytes = 256,
    parameter type vlsu_req_t    = logic,
    parameter type frag_txn_t    = logic
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      req_valid_i,
    output logic      req_ready_o,
    input  vlsu_req_t req_i,
    input  logic      core_st_pending_i,
    input  logic      meta_buf_full_i,
    output logic      txn_valid_o,
    input  logic      txn_ready_i,
    output frag_txn_t txn_o,
    output logic      meta_enq_valid_o,
    input  logic      flush_i,
    output logic      busy_o
);

    import riva_pkg::*;

    localparam int SizeW = $clog2(MaxBurstBytes) + 1;

    seg_state_e           state, state_nx;
    seg_req_t             cur;
    vlsu_req_t            head;
    riva_pkg::frag_txn_t  txn;
    logic                 full, empty, pop, push;
    logic [AddrWidth-1:0] addr, seg_next, seg_rem, stride, base, start_unit, start_str, room;
    logic [LenWidth-1:0]  nr, segs_left;
    logic [SizeW-1:0]     nb;
    logic [3:0]           eb;
    logic                 strided, blocked, first, last_seg, last_req, hs;

    vlsu_req_fifo #(.Depth(ReqQueueDepth), .T(vlsu_req_t)) i_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .flush (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (req_i),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign pop         = state == IDLE && !empty && !flush_i;
    assign req_ready_o = !flush_i && (!full || pop);
    assign push        = req_valid_i && req_ready_o;

    assign strided    = is_strided(cur.mop);
    assign eb         = elem_bytes(cur.sew);
    assign blocked    = core_st_pending_i || meta_buf_full_i;
    assign stride     = cur.stride[AddrWidth-1:0];
    assign base       = cur.base[AddrWidth-1:0];
    assign nr         = cur.len > cur.vstart ? cur.len - cur.vstart : '0;
    assign start_unit = base + (AddrWidth'(cur.vstart) << cur.sew);
    assign start_str  = base + AddrWidth'(cur.vstart) * stride;

    // Bytes left before the next page boundary; equals PageBytes when page-aligned.
    assign room     = AddrWidth'(PageBytes) - (addr & AddrWidth'(PageBytes - 1));
    assign nb       = SizeW'(size_min(64'(seg_rem), 64'(room), 64'(MaxBurstBytes)));
    assign last_seg = AddrWidth'(nb) == seg_rem;
    assign last_req = last_seg && segs_left == '0;

    assign txn_valid_o      = state == FRAG;
    assign hs               = txn_valid_o && txn_ready_i;
    assign meta_enq_valid_o = state == FRAG && first;
    assign busy_o           = !empty || state != IDLE;

    assign txn = '{req_id: cur.req_id, addr: 64'(addr), nbytes: NbytesWidth'(nb),
                   is_load: cur.is_load, last_seg: last_seg, last_req: last_req};
    assign txn_o = frag_txn_t'(txn);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = pop ? SEG_INIT : IDLE;
            SEG_INIT: state_nx = nr == '0 ? IDLE : blocked ? STALL : FRAG;
            STALL:    state_nx = blocked ? STALL : FRAG;
            FRAG:     state_nx = hs && last_req ? IDLE : FRAG;
        endcase
        if (flush_i) state_nx = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cur       <= '0;
            addr      <= '0;
            seg_next  <= '0;
            seg_rem   <= '0;
            segs_left <= '0;
            first     <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop) cur <= seg_req_t'(head);
            // first stays set through STALL so the meta pulse lands on the first FRAG cycle
            if (state == SEG_INIT) begin
                addr      <= strided ? start_str : start_unit;
                seg_next  <= start_str + stride;
                seg_rem   <= strided ? AddrWidth'(eb) : AddrWidth'(nr) << cur.sew;
                segs_left <= strided ? nr - LenWidth'(1) : '0;
                first     <= 1'b1;
            end else if (state == FRAG) begin
                first <= 1'b0;
                if (hs && !last_seg) begin
                    addr    <= addr + AddrWidth'(nb);
                    seg_rem <= seg_rem - AddrWidth'(nb);
                end else if (hs && !last_req) begin
                    addr      <= seg_next;
                    seg_next  <= seg_next + stride;
                    seg_rem   <= AddrWidth'(eb);
                    segs_left <= segs_left - LenWidth'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vlsu_seg_fragmenter.sv
// tb_vlsu_seg_fragmenter: directed vectors with hand-computed transactions for the segment fragmenter.
module tb_vlsu_seg_fragmenter;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    riva_pkg::seg_req_t  req = '0;
    logic                core_st_pending = 1'b0;
    logic                meta_buf_full = 1'b0;
    logic                txn_valid;
    logic                txn_ready = 1'b1;
    riva_pkg::frag_txn_t txn;
    logic                meta_enq_valid;
    logic                flush = 1'b0;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;
    int meta_cnt = 0;
    riva_pkg::frag_txn_t txq[$];

    always #5 clk = ~clk;

    vlsu_seg_fragmenter #(
        .ReqQueueDepth(2),
        .AddrWidth    (64),
        .PageBytes    (4096),
        .MaxBurstBytes(256),
        .vlsu_req_t   (riva_pkg::seg_req_t),
        .frag_txn_t   (riva_pkg::frag_txn_t)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_i            (req),
        .core_st_pending_i(core_st_pending),
        .meta_buf_full_i  (meta_buf_full),
        .txn_valid_o      (txn_valid),
        .txn_ready_i      (txn_ready),
        .txn_o            (txn),
        .meta_enq_valid_o (meta_enq_valid),
        .flush_i          (flush),
        .busy_o           (busy)
    );

    always @(negedge clk) begin
        if (txn_valid && txn_ready) txq.push_back(txn);
        if (meta_enq_valid) meta_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_txn(input string tag, input int idx, input logic [63:0] addr,
                           input logic [63:0] nb, input logic ls, input logic lr);
        if (idx < txq.size()) begin
            check({tag, "_addr"}, txq[idx].addr, addr);
            check({tag, "_nbytes"}, 64'(txq[idx].nbytes), nb);
            check({tag, "_last_seg"}, 64'(txq[idx].last_seg), 64'(ls));
            check({tag, "_last_req"}, 64'(txq[idx].last_req), 64'(lr));
        end else begin
            check({tag, "_missing"}, txq.size(), idx + 1);
        end
    endtask

    function automatic riva_pkg::seg_req_t mk(input logic [3:0] id, input logic strided,
                                              input logic [1:0] sew, input logic [15:0] len,
                                              input logic [15:0] vstart, input logic [63:0] base,
                                              input logic [63:0] stride);
        riva_pkg::seg_req_t r;
        r        = '0;
        r.req_id = id;
        r.is_load = 1'b1;
        r.mop    = strided ? riva_pkg::MOP_STRIDED : riva_pkg::MOP_UNIT;
        r.sew    = sew;
        r.len    = len;
        r.vstart = vstart;
        r.base   = base;
        r.stride = stride;
        return r;
    endfunction

    task automatic send(input riva_pkg::seg_req_t r);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req = r;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        check("send_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_state(input riva_pkg::seg_state_e s);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dut.state == s) break;
        end
        check("state_reached", dut.state, s);
    endtask

    task automatic clear();
        txq.delete();
        meta_cnt = 0;
    endtask

    initial begin
        #3;
        check("rst_req_ready", req_ready, 1);
        check("rst_txn_valid", txn_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_meta", meta_enq_valid, 0);
        #20 rst_n = 1'b1;

        // page crossing: 32 bytes from 0xFF0 split at 0x1000
        clear();
        send(mk(4'd1, 1'b0, 2'd2, 16'd8, 16'd0, 64'hFF0, 64'd0));
        wait_idle();
        check("t1_count", txq.size(), 2);
        chk_txn("t1_0", 0, 64'hFF0, 16, 1'b0, 1'b0);
        chk_txn("t1_1", 1, 64'h1000, 16, 1'b1, 1'b1);
        if (txq.size() > 0) check("t1_req_id", 64'(txq[0].req_id), 1);
        if (txq.size() > 0) check("t1_is_load", 64'(txq[0].is_load), 1);
        check("t1_meta", meta_cnt, 1);

        // burst cap: 600 bytes -> 256, 256, 88
        clear();
        send(mk(4'd2, 1'b0, 2'd0, 16'd600, 16'd0, 64'h0, 64'd0));
        wait_idle();
        check("t2_count", txq.size(), 3);
        chk_txn("t2_0", 0, 64'h0, 256, 1'b0, 1'b0);
        chk_txn("t2_1", 1, 64'h100, 256, 1'b0, 1'b0);
        chk_txn("t2_2", 2, 64'h200, 88, 1'b1, 1'b1);

        // negative stride with vstart offset
        clear();
        send(mk(4'd3, 1'b1, 2'd3, 16'd3, 16'd1, 64'h100, -64'sd16));
        wait_idle();
        check("t3_count", txq.size(), 2);
        chk_txn("t3_0", 0, 64'hF0, 8, 1'b1, 1'b0);
        chk_txn("t3_1", 1, 64'hE0, 8, 1'b1, 1'b1);
        check("t3_meta", meta_cnt, 1);

        // address wrap below zero
        clear();
        send(mk(4'd4, 1'b1, 2'd0, 16'd2, 16'd0, 64'h8, -64'sd16));
        wait_idle();
        check("t4_count", txq.size(), 2);
        chk_txn("t4_0", 0, 64'h8, 1, 1'b1, 1'b0);
        chk_txn("t4_1", 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1'b1, 1'b1);

        // meta buffer full holds the FSM in STALL for 5 cycles
        clear();
        meta_buf_full = 1'b1;
        send(mk(4'd5, 1'b0, 2'd0, 16'd4, 16'd0, 64'h2000, 64'd0));
        wait_state(riva_pkg::SEG_INIT);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("t5_stall_state", dut.state, riva_pkg::STALL);
            check("t5_stall_valid", txn_valid, 0);
            check("t5_stall_meta", meta_enq_valid, 0);
            if (k == 5) meta_buf_full = 1'b0;
        end
        @(negedge clk);
        check("t5_frag_state", dut.state, riva_pkg::FRAG);
        check("t5_frag_meta", meta_enq_valid, 1);
        wait_idle();
        check("t5_meta", meta_cnt, 1);
        check("t5_count", txq.size(), 1);
        chk_txn("t5_0", 0, 64'h2000, 4, 1'b1, 1'b1);

        // flush mid-FRAG with two requests queued and no ready
        clear();
        txn_ready = 1'b0;
        send(mk(4'd6, 1'b0, 2'd0, 16'd64, 16'd0, 64'h4000, 64'd0));
        send(mk(4'd7, 1'b0, 2'd0, 16'd64, 16'd0, 64'h5000, 64'd0));
        send(mk(4'd8, 1'b0, 2'd0, 16'd64, 16'd0, 64'h6000, 64'd0));
        wait_state(riva_pkg::FRAG);
        check("t6_full", req_ready, 0);
        flush = 1'b1;
        #1 check("t6_flush_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("t6_state", dut.state, riva_pkg::IDLE);
        check("t6_busy", busy, 0);
        check("t6_valid", txn_valid, 0);
        txn_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_busy_after", busy, 0);
        check("t6_count", txq.size(), 0);

        // empty request then a normal one
        clear();
        send(mk(4'd9, 1'b0, 2'd1, 16'd5, 16'd5, 64'h7000, 64'd0));
        send(mk(4'd10, 1'b0, 2'd1, 16'd2, 16'd0, 64'h3000, 64'd0));
        wait_idle();
        check("t7_count", txq.size(), 1);
        chk_txn("t7_0", 0, 64'h3000, 4, 1'b1, 1'b1);
        if (txq.size() > 0) check("t7_req_id", 64'(txq[0].req_id), 10);
        check("t7_meta", meta_cnt, 1);

        // core store pending stalls, then asynchronous reset mid-FRAG discards the request
        clear();
        core_st_pending = 1'b1;
        txn_ready = 1'b0;
        send(mk(4'd11, 1'b0, 2'd0, 16'd16, 16'd0, 64'h8000, 64'd0));
        wait_state(riva_pkg::STALL);
        check("t8_stall_valid", txn_valid, 0);
        core_st_pending = 1'b0;
        wait_state(riva_pkg::FRAG);
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_valid", txn_valid, 0);
        check("t8_rst_busy", busy, 0);
        check("t8_rst_ready", req_ready, 1);
        check("t8_rst_meta", meta_enq_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        txn_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t8_count", txq.size(), 0);
        check("t8_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule

// File: doc/vlsu_seg_fragmenter.md
VLSU_SEG_FRAGMENTER -- requirements
Module: vlsu_seg_fragmenter

Interface
REQ-001 SHALL have parameter ReqQueueDepth, default 2: request FIFO entries, power of two, at least 1.
REQ-002 SHALL have parameter AddrWidth, default 64: byte-address width.
REQ-003 SHALL have parameter PageBytes, default 4096: boundary no transaction crosses, power of two.
REQ-004 SHALL have parameter MaxBurstBytes, default 256: transaction size cap, power of two, at most PageBytes.
REQ-005 SHALL have type parameters vlsu_req_t (request) and frag_txn_t (transaction), both default logic.
REQ-006 SHALL have port clk_i, input, 1 bit: clock.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have ports req_valid_i (input, 1), req_ready_o (output, 1), req_i (input, vlsu_req_t): request handshake.
REQ-009 SHALL have port core_st_pending_i, input, 1 bit: core store pending, blocks issue.
REQ-010 SHALL have port meta_buf_full_i, input, 1 bit: downstream meta buffer full, blocks issue.
REQ-011 SHALL have ports txn_valid_o (output, 1), txn_ready_i (input, 1), txn_o (output, frag_txn_t): transaction handshake.
REQ-012 SHALL have port meta_enq_valid_o, output, 1 bit: one-cycle pulse per request at first issue.
REQ-013 SHALL have port flush_i, input, 1 bit: abort all work.
REQ-014 SHALL have port busy_o, output, 1 bit: FIFO not empty or FSM not IDLE.

Function
REQ-015 Requests SHALL enter a ReqQueueDepth FIFO.
- req_ready_o = !full || pop in the same cycle.
- The FSM SHALL pop the head when in IDLE and the FIFO is not empty.
REQ-016 FSM states SHALL be IDLE, SEG_INIT, STALL, FRAG.
- IDLE -> SEG_INIT on pop.
- SEG_INIT/STALL -> STALL if core_st_pending_i || meta_buf_full_i, else FRAG.
- FRAG -> IDLE on handshake of the final transaction.
REQ-017 Modes SHALL be unit-stride and strided (mop).
- eb = 1<<sew; nrElem = len - vstart.
- Unit-stride: one segment of nrElem*eb bytes starting at base + vstart*eb.
- Strided: nrElem segments of eb bytes; segment k starts at base + (vstart+k)*stride.
REQ-018 Each transaction size SHALL be min(segment bytes remaining, PageBytes - addr%PageBytes, MaxBurstBytes).
- After handshake, address advances by that size.
- Size width: clog2(MaxBurstBytes)+1.
REQ-019 txn_o SHALL carry reqId, addr, nbytes (1..MaxBurstBytes), isLoad, lastSeg (last transaction of segment), lastReq (last transaction of request).
REQ-020 txn_valid_o SHALL be high only in FRAG, with txn_o stable while valid and not ready; no combinational path from txn_ready_i to txn_valid_o.
REQ-021 meta_enq_valid_o SHALL pulse exactly one cycle, the first FRAG cycle of each request, even when STALL intervenes.
REQ-022 nrElem == 0 SHALL retire the request in SEG_INIT (SEG_INIT -> IDLE) with no transactions and no meta pulse.
REQ-023 Address arithmetic SHALL wrap modulo 2^AddrWidth; stride is signed two's complement.
REQ-024 flush_i SHALL, on the next edge, empty the FIFO, force IDLE and drop an un-handshaken transaction; a handshake in the flush cycle SHALL complete; req_ready_o SHALL be 0 during flush.
REQ-025 Simultaneous push and pop on a full FIFO SHALL succeed without loss.

Reset
REQ-026 On rst_ni low, asynchronously:
- FSM SHALL go to IDLE and the FIFO SHALL empty.
- txn_valid_o, meta_enq_valid_o and busy_o SHALL be 0; req_ready_o SHALL be 1.
REQ-027 Reset mid-FRAG SHALL discard the request with no further transactions.

Structure
REQ-028 frag_txn_t, mode decode helpers and the size-min function SHALL live in riva_pkg.
REQ-029 The request FIFO SHALL be a sub-module, vlsu_req_fifo.

Verification
REQ-030 Unit-stride, base 0xFF0, sew=2, len=8, vstart=0, PageBytes 4096 -> txns (0xFF0,16), (0x1000,16); lastReq on the second; one meta pulse.
REQ-031 Unit-stride, base 0x0, 600 B, MaxBurstBytes 256 -> txns of 256, 256, 88 bytes.
REQ-032 Strided, sew=3, len=3, vstart=1, stride=-16, base 0x100 -> txns (0xF0,8), (0xE0,8); lastSeg on both; lastReq on the second.
REQ-033 meta_buf_full_i held 5 cycles at SEG_INIT -> state STALL for 5 cycles, no txn_valid_o; meta pulse exactly once afterwards.
REQ-034 flush_i asserted mid-FRAG with 2 requests queued, txn_ready_i=0 -> next cycle IDLE, busy_o=0, no transaction issued.
REQ-035 len == vstart followed by a normal request -> first request issues nothing; second proceeds normally.
